register_bank: RTL
==================

// Module: register_bank
// PURPOSE
//   Parametrised successor to the single load register: DEPTH words of WIDTH bits,
//   one write port and two independent registered read ports.
//   A hardware clear sequencer initialises every word to INIT_VAL after reset or on
//   request, with busy asserted while the sweep runs.
//   Used as a small configuration/scratch register file beside datapath blocks.
// PARAMETERS
//   WIDTH     8        data word width in bits (>=1)
//   DEPTH     8        number of words (>=2; non-power-of-two allowed)
//   INIT_VAL  0        value written to every word by the clear sweep (WIDTH bits)
//   AW        derived  localparam = $clog2(DEPTH), address width
// PORTS
//   clk      in   1      clock; all state changes on rising edge
//   rst      in   1      synchronous reset, active-low
//   clr      in   1      start/restart clear sweep (1-cycle pulse or level)
//   load     in   1      write enable
//   waddr    in   AW     write address
//   wdata    in   WIDTH  write data
//   raddr_a  in   AW     read address, port A
//   rdata_a  out  WIDTH  registered read data, port A
//   raddr_b  in   AW     read address, port B
//   rdata_b  out  WIDTH  registered read data, port B
//   busy     out  1      1 while the clear sweep is in progress
//   err      out  1      1-cycle pulse: a write was rejected
// BEHAVIOUR
//   Reset (rst==0 at rising edge): state<=CLEAR, ptr<=0, busy<=1, err<=0,
//     rdata_a<=0, rdata_b<=0. Array contents are not touched by reset itself.
//   FSM states IDLE, CLEAR; busy is registered and equals (state==CLEAR).
//   CLEAR: each edge with rst==1 writes mem[ptr]<=INIT_VAL and increments ptr.
//     On the edge that writes ptr==DEPTH-1: state<=IDLE, busy<=0.
//     busy is therefore high for exactly DEPTH edges after rst is released.
//   IDLE, clr==1: state<=CLEAR, ptr<=0, busy<=1 on the next edge.
//   IDLE, load==1, clr==0, waddr<DEPTH: mem[waddr]<=wdata.
//   Rejected writes (no array change, err<=1 for one cycle):
//     load with waddr>=DEPTH; load during CLEAR; load together with clr.
//   clr during CLEAR restarts the sweep (ptr<=0), with no err.
//   rst==0 mid-sweep restarts it after release, with a full DEPTH-cycle busy.
//   Reads: rdata_x<=mem[raddr_x] on every edge, giving 1-cycle latency.
//     raddr_x>=DEPTH gives 0.
//     During CLEAR, rdata_x<=INIT_VAL regardless of address.
//     Read-first: a same-edge write to raddr_x returns the old value, and the new
//     value appears on the following cycle.
//   err is 0 on every cycle without a rejected write; it is not sticky.
// TESTING (WIDTH=8, DEPTH=8, INIT_VAL=0 unless stated)
//   1. rst=0 for 2 cycles, then release
//      -> busy=1 for exactly 8 cycles, then 0; reading addr 0..7 -> 8'h00.
//   2. load 3<=8'h55, load 5<=8'hAA, then raddr_a=3, raddr_b=5
//      -> one cycle later rdata_a=8'h55, rdata_b=8'hAA.
//      Write 3<=8'hFF while raddr_a=3 -> rdata_a=8'h55, then 8'hFF.
//   3. DEPTH=6 instance, load waddr=6 wdata=8'h77
//      -> err=1 for one cycle; addr 0..5 unchanged; raddr_a=7 -> rdata_a=8'h00.
//   4. IDLE with addr2=8'h3C, then clr=1 and load=1 (waddr=2, wdata=8'h99) together
//      -> err=1; busy=1 for 8 cycles; afterwards addr2 reads 8'h00.
//   5. load 4<=8'hF0 while busy=1 -> err=1; after the sweep addr4 reads 8'h00.
//   6. rst=0 asserted when ptr==3 mid-sweep, then released
//      -> sweep restarts; busy=1 for a full 8 cycles; rdata_a=rdata_b=8'h00 in reset.

Source files
------------

// File: rtl/register_bank.sv
// Register file with one write port and two registered read ports.
// A clear sequencer sweeps every word to INIT_VAL after reset or on request.
module register_bank #(
    parameter int                WIDTH    = 8,
    parameter int                DEPTH    = 8,
    parameter logic [WIDTH-1:0]  INIT_VAL = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         load,
    input  logic [$clog2(DEPTH)-1:0]     waddr,
    input  logic [WIDTH-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0]     raddr_a,
    output logic [WIDTH-1:0]             rdata_a,
    input  logic [$clog2(DEPTH)-1:0]     raddr_b,
    output logic [WIDTH-1:0]             rdata_b,
    output logic                         busy,
    output logic                         err
);

    localparam int                AW       = $clog2(DEPTH);
    localparam logic [AW:0]       DEPTH_V  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]     LAST_PTR = AW'(DEPTH-1);
    localparam logic [AW-1:0]     PTR_ZERO = {AW{1'b0}};
    localparam logic [WIDTH-1:0]  ZERO_W   = {WIDTH{1'b0}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    logic [WIDTH-1:0] mem_r [DEPTH];
    state_t           state_r;
    state_t           state_nx_s;
    logic [AW-1:0]    ptr_r;
    logic [AW-1:0]    ptr_nx_s;
    logic             busy_r;
    logic             err_r;
    logic [WIDTH-1:0] rdata_a_r;
    logic [WIDTH-1:0] rdata_b_r;

    logic             waddr_ok_s;
    logic             raddr_a_ok_s;
    logic             raddr_b_ok_s;
    logic             we_s;
    logic             reject_s;
    logic [AW-1:0]    wa_s;
    logic [WIDTH-1:0] wd_s;

    // Addresses can exceed DEPTH-1 when DEPTH is not a power of two.
    assign waddr_ok_s   = ({1'b0, waddr}   < DEPTH_V);
    assign raddr_a_ok_s = ({1'b0, raddr_a} < DEPTH_V);
    assign raddr_b_ok_s = ({1'b0, raddr_b} < DEPTH_V);

    // Sweep sequencer next state; clr restarts the sweep from word 0.
    always_comb begin
        state_nx_s = state_r;
        ptr_nx_s   = ptr_r;
        case (state_r)
            IDLE: begin
                if (clr) begin
                    state_nx_s = CLEAR;
                    ptr_nx_s   = PTR_ZERO;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CLEAR: begin
                if (clr) begin
                    ptr_nx_s = PTR_ZERO;
                end else if (ptr_r == LAST_PTR) begin
                    state_nx_s = IDLE;
                    ptr_nx_s   = PTR_ZERO;
                end else begin
                    ptr_nx_s = ptr_r + AW'(1);
                end
            end
            default: begin
                state_nx_s = CLEAR;
                ptr_nx_s   = PTR_ZERO;
            end
        endcase
    end

    // Array write arbitration: the sweep owns the port, host writes only in IDLE.
    always_comb begin
        we_s     = 1'b0;
        reject_s = 1'b0;
        wa_s     = waddr;
        wd_s     = wdata;
        if (state_r == CLEAR) begin
            we_s     = 1'b1;
            wa_s     = ptr_r;
            wd_s     = INIT_VAL;
            reject_s = load;
        end else if (load) begin
            if (clr || !waddr_ok_s) begin
                reject_s = 1'b1;
            end else begin
                we_s = 1'b1;
            end
        end else begin
            we_s = 1'b0;
        end
    end

    // Control and read-data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= CLEAR;
            ptr_r     <= PTR_ZERO;
            busy_r    <= 1'b1;
            err_r     <= 1'b0;
            rdata_a_r <= ZERO_W;
            rdata_b_r <= ZERO_W;
        end else begin
            state_r   <= state_nx_s;
            ptr_r     <= ptr_nx_s;
            busy_r    <= (state_nx_s == CLEAR);
            err_r     <= reject_s;
            rdata_a_r <= (state_r == CLEAR) ? INIT_VAL :
                         (raddr_a_ok_s ? mem_r[raddr_a] : ZERO_W);
            rdata_b_r <= (state_r == CLEAR) ? INIT_VAL :
                         (raddr_b_ok_s ? mem_r[raddr_b] : ZERO_W);
        end
    end

    // Storage array; contents survive reset and are only changed by writes.
    always_ff @(posedge clk) begin
        if (rst && we_s) begin
            mem_r[wa_s] <= wd_s;
        end
    end

    assign rdata_a = rdata_a_r;
    assign rdata_b = rdata_b_r;
    assign busy    = busy_r;
    assign err     = err_r;

endmodule
